// File: rtl/conv_encoder_if.sv
// Symbol stream interface for conv_encoder: input bit stream in, 2-bit
// symbol stream out, both with valid/ready handshakes.
// master: the side that drives bits and consumes symbols (source/sink).
// slave:  the encoder itself.
interface conv_encoder_if;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_sym;
    logic       out_ready;
    logic       out_last;

    modport master (
        output in_valid,
        output in_bit,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sym,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sym,
        output out_last
    );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2, K=4 (8-state) convolutional encoder with frame termination.
//
// Optional feature macro: CONV_ENC_TAIL_EN
//   defined     - each frame is followed by three zero-tail symbols that
//                 flush the encoder back to state 0; out_last marks the
//                 third tail symbol.
//   not defined - no tail; out_last marks the symbol of the last data bit
//                 and the shift register is truncated to 0 in that cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | held off by enable=0 (or just out of reset); sr and count are 0
// DATA  | accepting data bits, one symbol per accepted bit
// TAIL  | emitting the three zero-input flush symbols (tail build only)
module conv_encoder #(
    parameter int unsigned FRAME_LEN = 8,
    parameter logic [3:0]  G0        = 4'b1101,
    parameter logic [3:0]  G1        = 4'b1111
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    output logic          busy_o,
    conv_encoder_if.slave bus
);

    localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

`ifdef CONV_ENC_TAIL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1
    } state_t;
`endif

    state_t           state_q;
    logic [2:0]       sr_q;
    logic [CNT_W-1:0] cnt_q;
`ifdef CONV_ENC_TAIL_EN
    logic [1:0]       tail_q;
`endif
    logic             out_valid_q;
    logic [1:0]       out_sym_q;
    logic             out_last_q;

    logic             adv_d;
    logic             accept_d;
    logic [1:0]       sym_data_d;
    logic [1:0]       sym_tail_d;
    logic [2:0]       sr_data_d;

    // Tap vector is {b, sr[0], sr[1], sr[2]}; generator bit 3 taps b.
    function automatic logic [1:0] encode(input logic b, input logic [2:0] sr);
        logic [3:0] taps;
        taps   = {b, sr[0], sr[1], sr[2]};
        encode = {^(G1 & taps), ^(G0 & taps)};
    endfunction

    // Output register is free when empty or being consumed this cycle.
    assign adv_d    = !out_valid_q || bus.out_ready;
    assign accept_d = (state_q == S_DATA) && adv_d && bus.in_valid;

    // Candidate symbols and shift-register update for data and tail encodes.
    always_comb begin
        sym_data_d = encode(bus.in_bit, sr_q);
        sym_tail_d = encode(1'b0, sr_q);
        sr_data_d  = {sr_q[1:0], bus.in_bit};
    end

    // Frame FSM together with the shift register, counters and output stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
`ifdef CONV_ENC_TAIL_EN
            tail_q      <= '0;
`endif
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'b00;
            out_last_q  <= 1'b0;
        end else if (!enable_i) begin
            // Abort: the partial frame is dropped, including a pending symbol.
            state_q     <= S_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
`ifdef CONV_ENC_TAIL_EN
            tail_q      <= '0;
`endif
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sr_q    <= '0;
                    cnt_q   <= '0;
                    state_q <= S_DATA;
                end

                S_DATA: begin
                    if (accept_d) begin
                        out_valid_q <= 1'b1;
                        out_sym_q   <= sym_data_d;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
`ifdef CONV_ENC_TAIL_EN
                            out_last_q <= 1'b0;
                            sr_q       <= sr_data_d;
                            state_q    <= S_TAIL;
`else
                            // Truncated frame: next frame restarts from state 0.
                            out_last_q <= 1'b1;
                            sr_q       <= '0;
`endif
                        end else begin
                            cnt_q      <= cnt_q + 1'b1;
                            out_last_q <= 1'b0;
                            sr_q       <= sr_data_d;
                        end
                    end else if (adv_d) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end

`ifdef CONV_ENC_TAIL_EN
                S_TAIL: begin
                    if (adv_d) begin
                        out_valid_q <= 1'b1;
                        out_sym_q   <= sym_tail_d;
                        if (tail_q == 2'd2) begin
                            // Three zeros have shifted through, so sr is 0.
                            tail_q     <= '0;
                            sr_q       <= '0;
                            out_last_q <= 1'b1;
                            state_q    <= S_DATA;
                        end else begin
                            tail_q     <= tail_q + 1'b1;
                            sr_q       <= {sr_q[1:0], 1'b0};
                            out_last_q <= 1'b0;
                        end
                    end
                end
`endif

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_DATA) && adv_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_last  = out_last_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-4 (8-state) convolutional encoder with a zero-tail frame terminator. It sits at the transmit end of the Viterbi link and produces the 2-bit symbols that the decoder's branch-metric, ACS and traceback stages consume. Each frame is flushed back to state 0 so decoder traceback can start from state 0. Valid/ready handshakes on both sides allow back-pressure from the channel model or the symbol FIFO.

## Interface
- `FRAME_LEN`, default 8: number of data bits per frame; must be ≥ 1.
- `G0`, default 4'b1101: generator for `out_sym[0]`; bit 3 taps the current input.
- `G1`, default 4'b1111: generator for `out_sym[1]`.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  synchronous run enable; low aborts and holds the block idle.
- `in_valid`  in  1  `in_bit` is presented.
- `in_bit`  in  1  data bit.
- `in_ready`  out  1  the block accepts `in_bit` this cycle.
- `out_valid`  out  1  `out_sym` is valid.
- `out_sym`  out  2  encoded symbol {G1 parity, G0 parity}.
- `out_ready`  in  1  downstream accepts `out_sym`.
- `out_last`  out  1  marks the final symbol of the frame.
- `busy`  out  1  state is not IDLE.

## Operation
- Shift register `sr[2:0]`: `sr[0]` holds the newest bit and `sr[2]` the oldest.
- Tap vector t = {b, sr[0], sr[1], sr[2]}, where b is the bit being encoded.
- Parity: `out_sym[k]` = XOR-reduce(Gk & t).
- After each encode: `sr` ← {sr[1], sr[0], b}.
- Output stage: a single register holding `out_sym`, `out_valid` and `out_last`.
- Stage free ("adv") = `!out_valid || out_ready`.
- State machine:
  - IDLE: `sr`=0, count=0. Moves to DATA on the next edge when `enable`=1.
  - DATA: `in_ready` = adv. Each `in_valid && in_ready` encodes `in_bit`, loads the output register and increments count.
  - DATA → TAIL: on acceptance of bit number `FRAME_LEN`; count is cleared.
  - TAIL: with adv, encodes b=0 on each cycle and loads the output register; 3 tail symbols in total.
  - TAIL → DATA: on loading the 3rd tail symbol, with `out_last`=1 and `sr`=0. Back-to-back frames follow with no gap.
- If adv=0, the output register holds its value and nothing is encoded.
- If `enable`=0 in any state: go to IDLE; clear `sr`, count, `out_valid` and `out_last`. The partial frame is discarded. `enable` has priority over every handshake.
- `in_ready`=0 in IDLE and TAIL.

## Timing
- Reset values: state=IDLE, `sr`=0, count=0. Outputs: `in_ready`=0, `out_valid`=0, `out_sym`=2'b00, `out_last`=0, `busy`=0.
- Latency: a bit accepted at edge n appears on `out_sym` with `out_valid`=1 after edge n (one cycle).
- Throughput: one symbol per cycle while `out_ready`=1. A frame takes FRAME_LEN+3 symbol cycles.
- `in_ready` is combinational from state and `out_ready`. There is no combinational path from `in_valid` to any output.
- Output hold: `out_valid` and `out_sym` stay stable until accepted (`out_valid && out_ready`).
- Simultaneous accept-and-reload in one cycle is required (no bubble).
- Reset asserted mid-frame: all outputs clear immediately (asynchronous reset).

## Configuration
- `CONV_ENC_TAIL_EN` defined: zero-tail termination as described; the TAIL state exists and `out_last` is on the 3rd tail symbol.
- Not defined: the TAIL state is removed.
  - `out_last` is on the symbol of data bit `FRAME_LEN`.
  - In the same cycle, `sr` is cleared to 0 (truncated frame) and the state stays in DATA.
  - A frame is FRAME_LEN symbols.

## Test plan
1. **Impulse.** Defaults, tail enabled, `out_ready`=1; bits 1,0,0,0,0,0,0,0 → `out_sym` 11,11,10,11,00,00,00,00,00,00,00. `out_last` only on the 11th symbol.
2. **Tail flush.** Bits 0,0,0,0,0,0,0,1 → seven 00, then 11, then tail 11,10,11 with `out_last` on the last. `in_ready`=0 during the three tail cycles.
3. **Back-pressure.** As scenario 1, with `out_ready` toggled 1,0,0,1,...:
   - `out_sym` holds while stalled and the sequence is unchanged.
   - `in_ready`=0 whenever `out_valid`=1 and `out_ready`=0.
4. **Abort.** Drop `enable` after bit 5 of a frame of all-1s:
   - Next cycle: `out_valid`=0 and `busy`=0.
   - Re-enable and send 1,0,0,0,0,0,0,0 → the output matches scenario 1 exactly.
5. **Async reset.** Assert `rst`=0 between clock edges mid-TAIL → all outputs read reset values before the next edge. The next frame after release is correct.
6. **Tail compiled out.** Without `CONV_ENC_TAIL_EN`, two back-to-back frames of 0,0,0,0,0,0,0,1 → each frame is 00×7 then 11, with `out_last` on symbol 8. The second frame starts from `sr`=0.
